// File: rtl/bcd_display_formatter_if.sv
// ============================================================================
// Module      : bcd_display_formatter_if
// Description : Request/result bundle between a producer and the BCD display
//               formatter (binary request in, packed BCD + digit mask out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_display_formatter_if #(
    parameter int DIN_W = 26
);
    logic             start;
    logic [DIN_W-1:0] bin;
    logic             lz_blank;
    logic             busy;
    logic             done;
    logic [31:0]      data;
    logic [7:0]       enable;

    modport master (
        output start, bin, lz_blank,
        input  busy, done, data, enable
    );

    modport slave (
        input  start, bin, lz_blank,
        output busy, done, data, enable
    );
endinterface

`default_nettype wire

// File: rtl/bcd_display_formatter.sv
// ============================================================================
// Module      : bcd_display_formatter
// Description : Sequential double-dabble binary to 8-digit packed BCD with a
//               double-buffered result and leading-zero digit-enable mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_formatter #(
    parameter int DIN_W      = 26,
    parameter int MIN_DIGITS = 1
) (
    input wire logic               clk,
    input wire logic               rst,
    bcd_display_formatter_if.slave bus
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    localparam int                 c_CNT_W    = $clog2(DIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DIN_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Mask shown for a zero value: the lowest MIN_DIGITS digits lit.
    localparam logic [8:0] c_ONE9      = 9'd1;
    localparam logic [7:0] c_ZERO_MASK = 8'((c_ONE9 << MIN_DIGITS) - 9'd1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_busy;
    logic               w_load;
    logic               w_shift;
    logic               w_commit;

    logic [DIN_W-1:0]   r_sh;
    logic [31:0]        r_acc;
    logic [c_CNT_W-1:0] r_count;
    logic               r_lzb;
    logic [31:0]        r_data;
    logic [7:0]         r_enable;
    logic               r_done;

    logic [31:0]        w_adj;
    logic [7:0]         w_nz;
    logic [7:0]         w_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (bus.start) w_next_state = c_S_SHIFT;
            c_S_SHIFT: if (r_count == c_CNT_ONE) w_next_state = c_S_DONE;
            c_S_DONE:  w_next_state = c_S_IDLE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            c_S_IDLE:  w_load = bus.start;
            c_S_SHIFT: begin
                w_busy  = 1'b1;
                w_shift = 1'b1;
            end
            c_S_DONE:  begin
                w_busy   = 1'b1;
                w_commit = 1'b1;
            end
            default:   w_busy = 1'b0;
        endcase
    end

    // Per-digit add-3 correction and leading-zero mask. A digit is lit when
    // blanking is off, it is within the forced minimum, or any digit at or
    // above it is nonzero.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_digit
            assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                                : r_acc[4*i +: 4];
            assign w_nz[i]   = |r_acc[4*i +: 4];
            assign w_mask[i] = ~r_lzb | ((i < MIN_DIGITS) ? 1'b1 : 1'b0) | (|w_nz[7:i]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh     <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_lzb    <= 1'b0;
            r_data   <= 32'h0;
            r_enable <= c_ZERO_MASK;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_load) begin
                r_sh    <= bus.bin;
                r_acc   <= '0;
                r_count <= c_CNT_LOAD;
                r_lzb   <= bus.lz_blank;
            end
            if (w_shift) begin
                // Top bit of the corrected accumulator is always zero for DIN_W <= 26.
                r_acc   <= 32'({w_adj, r_sh[DIN_W-1]});
                r_sh    <= r_sh << 1;
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_commit) begin
                r_data   <= r_acc;
                r_enable <= w_mask;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.data   = r_data;
    assign bus.enable = r_enable;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_formatter.sv
// ============================================================================
// Module      : tb_bcd_display_formatter
// Description : Scoreboard bench for bcd_display_formatter; three instances
//               (MIN_DIGITS = 1, 3, 0) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_formatter;

    localparam int DIN_W = 26;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_display_formatter_if #(.DIN_W(DIN_W)) bus1 ();
    bcd_display_formatter_if #(.DIN_W(DIN_W)) bus3 ();
    bcd_display_formatter_if #(.DIN_W(DIN_W)) bus0 ();

    bcd_display_formatter #(.DIN_W(DIN_W), .MIN_DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    bcd_display_formatter #(.DIN_W(DIN_W), .MIN_DIGITS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    bcd_display_formatter #(.DIN_W(DIN_W), .MIN_DIGITS(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        q1[$];
    exp_t        q3[$];
    exp_t        q0[$];
    logic [31:0] last_d;
    logic [7:0]  last_e;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_mask(input logic [31:0] bcd, input logic lzb, input int mind);
        int k = -1;
        int top;
        logic [7:0] m = '0;
        if (!lzb) return 8'hFF;
        for (int i = 0; i < 8; i++) if (bcd[4*i +: 4] != 4'd0) k = i;
        top = (k > mind - 1) ? k : mind - 1;
        for (int i = 0; i < 8; i++) if (i <= top) m[i] = 1'b1;
        return m;
    endfunction

    task automatic drive(input logic s, input int unsigned b, input logic l);
        bus1.start = s; bus1.bin = DIN_W'(b); bus1.lz_blank = l;
        bus3.start = s; bus3.bin = DIN_W'(b); bus3.lz_blank = l;
        bus0.start = s; bus0.bin = DIN_W'(b); bus0.lz_blank = l;
    endtask

    task automatic push_exp(input int unsigned b, input logic l);
        exp_t e;
        e.d = to_bcd(b);
        e.e = exp_mask(e.d, l, 1); q1.push_back(e);
        e.e = exp_mask(e.d, l, 3); q3.push_back(e);
        e.e = exp_mask(e.d, l, 0); q0.push_back(e);
    endtask

    // One conversion; poke re-pulses start mid-conversion and in the DONE cycle.
    task automatic convert(input int unsigned b, input logic l, input bit poke);
        int n = 0;
        bit got = 1'b0;
        while (bus1.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        drive(1'b1, b, l);
        push_exp(b, l);
        @(posedge clk);
        #1;
        drive(1'b0, $urandom_range(0, 67108863), 1'($urandom));
        check("busy_rise", 32'(bus1.busy), 32'd1);
        n = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (bus1.done) got = 1'b1;
            else if (n == 13) begin
                check("hold_data", bus1.data, last_d);
                check("hold_enable", 32'(bus1.enable), 32'(last_e));
            end
            if (poke && (n == 5 || n == 26)) drive(1'b1, $urandom_range(0, 67108863), 1'b0);
            else drive(1'b0, $urandom_range(0, 67108863), 1'b0);
        end
        drive(1'b0, 0, 1'b0);
        check("latency", 32'(n), 32'(DIN_W + 1));
        last_d = to_bcd(b);
        last_e = exp_mask(last_d, l, 1);
    endtask

    always @(negedge clk) begin : m1
        exp_t e;
        if (!rst && bus1.done) begin
            if (q1.size() == 0) check("unexpected_done1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("data1", bus1.data, e.d);
                check("enable1", 32'(bus1.enable), 32'(e.e));
            end
        end
    end

    always @(negedge clk) begin : m3
        exp_t e;
        if (!rst && bus3.done) begin
            if (q3.size() == 0) check("unexpected_done3", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                check("data3", bus3.data, e.d);
                check("enable3", 32'(bus3.enable), 32'(e.e));
            end
        end
    end

    always @(negedge clk) begin : m0
        exp_t e;
        if (!rst && bus0.done) begin
            if (q0.size() == 0) check("unexpected_done0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("data0", bus0.data, e.d);
                check("enable0", 32'(bus0.enable), 32'(e.e));
            end
        end
    end

    initial begin
        rst = 1'b1;
        last_d = 32'h0;
        last_e = 8'h01;
        drive(1'b1, 12345, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", bus1.data, 32'h0);
        check("rst_enable1", 32'(bus1.enable), 32'h01);
        check("rst_enable3", 32'(bus3.enable), 32'h07);
        check("rst_enable0", 32'(bus0.enable), 32'h00);
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_done", 32'(bus1.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("no_start_in_rst", 32'(bus1.busy), 32'd0);

        convert(12345678, 1'b1, 1'b0);
        convert(67108863, 1'b1, 1'b0);
        convert(305, 1'b1, 1'b0);
        convert(305, 1'b0, 1'b0);
        convert(0, 1'b1, 1'b0);
        convert(7, 1'b1, 1'b0);
        convert(0, 1'b0, 1'b0);
        convert(40020, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_idle", 32'(bus1.busy), 32'd0);

        // Abort mid-conversion with reset.
        @(negedge clk);
        drive(1'b1, 999, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_data", bus1.data, 32'h0);
        check("abort_enable1", 32'(bus1.enable), 32'h01);
        check("abort_enable3", 32'(bus3.enable), 32'h07);
        check("abort_enable0", 32'(bus0.enable), 32'h00);
        check("abort_busy", 32'(bus1.busy), 32'd0);
        check("abort_done", 32'(bus1.done), 32'd0);
        last_d = 32'h0;
        last_e = 8'h01;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_busy", 32'(bus1.busy), 32'd0);

        convert(86420, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) convert($urandom_range(0, 67108863) >> $urandom_range(0, 25), 1'($urandom), 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("queue1_empty", 32'(q1.size()), 32'd0);
        check("queue3_empty", 32'(q3.size()), 32'd0);
        check("queue0_empty", 32'(q0.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
